// File: rtl/bitbrick_dot_acc_if.sv
// bitbrick_dot_acc_if
//   Bundles the beat-input and result-output handshakes of bitbrick_dot_acc.
//   master : the producer/consumer side (activation/weight buffers feeding
//            beats in, output quantiser taking results out).
//   slave  : the dot-product engine itself.
//   Signals:
//     in_valid/in_ready/in_last : beat handshake, in_last marks end of group
//     bin, SignI, SignW         : mode for the group (sampled on first beat)
//     I, W                      : LANES 2-bit activation / weight bricks
//     out_valid/out_ready       : result handshake
//     out_data/out_count/out_sat: signed group sum, beat count, saturation
interface bitbrick_dot_acc_if #(
    parameter int LANES = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic                    bin;
    logic                    SignI;
    logic                    SignW;
    logic [2*LANES-1:0]      I;
    logic [2*LANES-1:0]      W;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;

    modport master (
        output in_valid, in_last, bin, SignI, SignW, I, W, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_last, bin, SignI, SignW, I, W, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/bitbrick_dot_acc.sv
// bitbrick_dot_acc
//   Three-stage pipelined dot-product engine built from LANES 2-bit
//   bit-bricks. Each beat is either an integer 2x2-bit multiply per lane
//   (signedness chosen by SignI/SignW) or a binary XNOR/popcount over
//   2*LANES +-1 elements. Beat sums accumulate over a group ended by
//   in_last into a saturating ACC_W-bit accumulator.
//   Ports:
//     clk  : clock, rising edge
//     rstn : synchronous active-low reset
//     bus  : bitbrick_dot_acc_if slave modport (beat in, result out)
module bitbrick_dot_acc #(
    parameter int LANES = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rstn,
    bitbrick_dot_acc_if.slave bus
);

    // Beat sum width: 5-bit lane products plus log2(LANES) growth, with one
    // spare bit so the binary-mode doubling never overflows.
    localparam int SUM_W = $clog2(LANES) + 6;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [SUM_W-1:0] BIN_OFS = SUM_W'(2 * LANES);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [4:0] ext2(input logic [1:0] v, input logic s);
        ext2 = s ? {{3{v[1]}}, v} : {3'b000, v};
    endfunction

    logic en;
    logic grp_open;
    logic bin_l, signi_l, signw_l;
    logic mode_bin, mode_si, mode_sw;

    logic                    s1_valid, s1_last, s1_bin;
    logic signed [4:0]       s1_prod [LANES];
    logic signed [4:0]       prod_c  [LANES];

    logic                    s2_valid, s2_last;
    logic signed [SUM_W-1:0] s2_sum;
    logic signed [SUM_W-1:0] psum, beat_sum;

    logic signed [ACC_W-1:0] acc, acc_next;
    logic signed [EXT_W-1:0] wide_sum;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    sat_sticky, sat_now;

    logic                    out_valid_q, out_sat_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0]        out_count_q;

    // The whole pipeline freezes only while a result waits for its consumer.
    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

    // The first beat of a group uses the live mode pins; later beats reuse
    // the values latched on that first beat.
    always_comb begin
        mode_bin = grp_open ? bin_l   : bus.bin;
        mode_si  = grp_open ? signi_l : bus.SignI;
        mode_sw  = grp_open ? signw_l : bus.SignW;
    end

    // Per-lane bit-brick: binary mode counts matching bits (0..2), integer
    // mode multiplies the extended operands; both fit a 5-bit signed lane.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_c[k] = '0;
            if (mode_bin) begin
                prod_c[k] = {4'b0000, ~(bus.I[2*k]   ^ bus.W[2*k])}
                          + {4'b0000, ~(bus.I[2*k+1] ^ bus.W[2*k+1])};
            end else begin
                prod_c[k] = ext2(bus.I[2*k +: 2], mode_si) * ext2(bus.W[2*k +: 2], mode_sw);
            end
        end
    end

    // Stage 1: capture lane products and track the group-open / mode latch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bin   <= 1'b0;
            s1_prod  <= '{default: '0};
            grp_open <= 1'b0;
            bin_l    <= 1'b0;
            signi_l  <= 1'b0;
            signw_l  <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_last;
            s1_bin   <= mode_bin;
            s1_prod  <= prod_c;
            if (bus.in_valid) begin
                if (!grp_open) begin
                    bin_l   <= bus.bin;
                    signi_l <= bus.SignI;
                    signw_l <= bus.SignW;
                end
                grp_open <= !bus.in_last;
            end
        end
    end

    // Adder tree; binary mode maps the match count onto a +-1 dot product.
    always_comb begin
        psum = '0;
        for (int k = 0; k < LANES; k++) begin
            psum = psum + SUM_W'(s1_prod[k]);
        end
        beat_sum = s1_bin ? ((psum <<< 1) - BIN_OFS) : psum;
    end

    // Stage 2: register the beat sum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= beat_sum;
        end
    end

    // The accumulator is zeroed whenever a group closes, so it already
    // serves as the zero base for the first beat of the next group.
    always_comb begin
        wide_sum = EXT_W'(acc) + EXT_W'(s2_sum);
        sat_now  = 1'b0;
        acc_next = wide_sum[ACC_W-1:0];
        if (wide_sum > EXT_W'(ACC_MAX)) begin
            acc_next = ACC_MAX;
            sat_now  = 1'b1;
        end else if (wide_sum < EXT_W'(ACC_MIN)) begin
            acc_next = ACC_MIN;
            sat_now  = 1'b1;
        end
        cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    // Stage 3: accumulate, and on the last beat publish the result and
    // clear group state so the next beat starts a new group immediately.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc         <= '0;
            cnt         <= '0;
            sat_sticky  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_next;
                    out_count_q <= cnt_next;
                    out_sat_q   <= sat_sticky | sat_now;
                    acc         <= '0;
                    cnt         <= '0;
                    sat_sticky  <= 1'b0;
                end else begin
                    acc         <= acc_next;
                    cnt         <= cnt_next;
                    sat_sticky  <= sat_sticky | sat_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitbrick_dot_acc.sv
// tb_bitbrick_dot_acc
//   Directed self-checking bench for bitbrick_dot_acc. Instance dut_a uses
//   ACC_W=24, instance dut_b uses ACC_W=8 to reach saturation quickly.
//   Results are collected at the negative edge whenever a handshake will
//   complete and compared against hand-computed values.
module tb_bitbrick_dot_acc;

    logic clk;
    logic rstn;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        int c;
        int s;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    bitbrick_dot_acc_if #(.LANES(16), .ACC_W(24), .CNT_W(16)) ba ();
    bitbrick_dot_acc_if #(.LANES(16), .ACC_W(8),  .CNT_W(16)) bb ();

    bitbrick_dot_acc #(.LANES(16), .ACC_W(24), .CNT_W(16)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ba)
    );

    bitbrick_dot_acc #(.LANES(16), .ACC_W(8), .CNT_W(16)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture each result that the upcoming rising edge will consume.
    always @(negedge clk) begin
        if (rstn && ba.out_valid && ba.out_ready)
            qa.push_back('{int'(ba.out_data), int'(ba.out_count), int'(ba.out_sat)});
        if (rstn && bb.out_valid && bb.out_ready)
            qb.push_back('{int'(bb.out_data), int'(bb.out_count), int'(bb.out_sat)});
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat on the selected DUT and hold it until accepted.
    task automatic applyStimulus(input bit sel, input bit binm, input bit si, input bit sw,
                                 input logic [1:0] ib, input logic [1:0] wb, input bit last);
        int guard;
        if (!sel) begin
            ba.in_valid = 1'b1; ba.bin = binm; ba.SignI = si; ba.SignW = sw;
            ba.I = {16{ib}};    ba.W = {16{wb}}; ba.in_last = last;
        end else begin
            bb.in_valid = 1'b1; bb.bin = binm; bb.SignI = si; bb.SignW = sw;
            bb.I = {16{ib}};    bb.W = {16{wb}}; bb.in_last = last;
        end
        #0;
        guard = 0;
        while (!(sel ? bb.in_ready : ba.in_ready) && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard == 50) checkOutput("accept_timeout", 0, 1);
        tick(1);
        if (!sel) ba.in_valid = 1'b0;
        else      bb.in_valid = 1'b0;
    endtask

    task automatic checkResult(input bit sel, input string tag, input int d, input int c, input int s);
        res_t r;
        if ((sel ? qb.size() : qa.size()) == 0) begin
            checkOutput({tag, "_present"}, 0, 1);
        end else begin
            r = sel ? qb.pop_front() : qa.pop_front();
            checkOutput({tag, "_data"},  r.d, d);
            checkOutput({tag, "_count"}, r.c, c);
            checkOutput({tag, "_sat"},   r.s, s);
        end
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_extra_a"}, qa.size(), 0);
        checkOutput({tag, "_extra_b"}, qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rstn = 1'b0;
        ba.in_valid = 1'b0; ba.in_last = 1'b0; ba.bin = 1'b0; ba.SignI = 1'b0; ba.SignW = 1'b0;
        ba.I = '0; ba.W = '0; ba.out_ready = 1'b1;
        bb.in_valid = 1'b0; bb.in_last = 1'b0; bb.bin = 1'b0; bb.SignI = 1'b0; bb.SignW = 1'b0;
        bb.I = '0; bb.W = '0; bb.out_ready = 1'b1;

        // Reset state
        tick(3);
        checkOutput("rst_out_valid", int'(ba.out_valid), 0);
        checkOutput("rst_out_data",  int'(ba.out_data),  0);
        checkOutput("rst_out_count", int'(ba.out_count), 0);
        checkOutput("rst_out_sat",   int'(ba.out_sat),   0);
        checkOutput("rst_in_ready",  int'(ba.in_ready),  1);
        rstn = 1'b1;
        tick(1);

        // Unsigned 3x3 single beat: 16*9 = 144, valid after the second edge
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 1);
        checkOutput("lat_e0", int'(ba.out_valid), 0);
        tick(1);
        checkOutput("lat_e1", int'(ba.out_valid), 0);
        tick(1);
        checkOutput("lat_e2_valid", int'(ba.out_valid), 1);
        checkOutput("lat_e2_data",  int'(ba.out_data),  144);
        tick(1);
        checkOutput("lat_e3_valid", int'(ba.out_valid), 0);
        checkResult(0, "uns", 144, 1, 0);
        checkDrained("uns");

        // Signed (-2*-2)*16 = 64, then mixed (-2*3)*16 = -96, back-to-back
        applyStimulus(0, 0, 1, 1, 2'b10, 2'b10, 1);
        applyStimulus(0, 0, 1, 0, 2'b10, 2'b11, 1);
        tick(1);
        checkOutput("b2b_v1", int'(ba.out_valid), 1);
        checkOutput("b2b_d1", int'(ba.out_data), 64);
        tick(1);
        checkOutput("b2b_v2", int'(ba.out_valid), 1);
        checkOutput("b2b_d2", int'(ba.out_data), -96);
        tick(1);
        checkOutput("b2b_v3", int'(ba.out_valid), 0);
        checkResult(0, "b2b_a", 64, 1, 0);
        checkResult(0, "b2b_b", -96, 1, 0);
        checkDrained("b2b");

        // Binary 3 beats: +32, -32, +32 with bin toggled on beats 2-3
        applyStimulus(0, 1, 0, 0, 2'b11, 2'b11, 0);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b00, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 2'b00, 1);
        tick(4);
        checkResult(0, "bin3", 32, 3, 0);
        // Integer group with bin raised on the last beat: 144 + 0
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 0);
        applyStimulus(0, 1, 0, 0, 2'b11, 2'b00, 1);
        // Unsigned group with signs raised on beat 2: (2*2 + 2*3)*16 = 160
        applyStimulus(0, 0, 0, 0, 2'b10, 2'b10, 0);
        applyStimulus(0, 0, 1, 1, 2'b10, 2'b11, 1);
        tick(4);
        checkResult(0, "binlatch", 144, 2, 0);
        checkResult(0, "signlatch", 160, 2, 0);
        checkDrained("latch");

        // Saturation on the 8-bit instance
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 1);
        applyStimulus(1, 0, 0, 0, 2'b00, 2'b00, 1);
        // Sticky: 64 + 64 -> 127 (sat), then -16 -> 111
        applyStimulus(1, 0, 1, 1, 2'b10, 2'b10, 0);
        applyStimulus(1, 0, 1, 1, 2'b10, 2'b10, 0);
        applyStimulus(1, 0, 1, 1, 2'b01, 2'b11, 1);
        // Negative: -96 + -96 -> -128
        applyStimulus(1, 0, 1, 0, 2'b10, 2'b11, 0);
        applyStimulus(1, 0, 1, 0, 2'b10, 2'b11, 1);
        tick(4);
        checkResult(1, "sat_pos", 127, 1, 1);
        checkResult(1, "sat_zero", 0, 1, 0);
        checkResult(1, "sat_sticky", 111, 3, 1);
        checkResult(1, "sat_neg", -128, 2, 1);
        checkDrained("sat");

        // Backpressure: results 16, 32, 48 with a 5-cycle stall on the first
        ba.out_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 2'b01, 2'b01, 1);
        applyStimulus(0, 0, 0, 0, 2'b10, 2'b01, 1);
        tick(1);
        checkOutput("bp_valid0", int'(ba.out_valid), 1);
        checkOutput("bp_data0",  int'(ba.out_data), 16);
        checkOutput("bp_ready0", int'(ba.in_ready), 0);
        ba.in_valid = 1'b1; ba.bin = 1'b0; ba.SignI = 1'b0; ba.SignW = 1'b0;
        ba.I = {16{2'b11}}; ba.W = {16{2'b01}}; ba.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput($sformatf("bp_hold_valid%0d", i), int'(ba.out_valid), 1);
            checkOutput($sformatf("bp_hold_data%0d", i),  int'(ba.out_data), 16);
            checkOutput($sformatf("bp_hold_ready%0d", i), int'(ba.in_ready), 0);
        end
        ba.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", int'(ba.in_ready), 1);
        @(posedge clk);
        #1;
        ba.in_valid = 1'b0;
        checkOutput("bp_next_valid", int'(ba.out_valid), 1);
        checkOutput("bp_next_data",  int'(ba.out_data), 32);
        tick(4);
        checkResult(0, "bp_g1", 16, 1, 0);
        checkResult(0, "bp_g2", 32, 1, 0);
        checkResult(0, "bp_g3", 48, 1, 0);
        checkDrained("bp");

        // Reset mid-group discards the partial group
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 0);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 0);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 1);
        tick(4);
        checkResult(0, "midrst", 144, 1, 0);
        checkDrained("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
